// File: rtl/add8_rr_scheduler.sv
// add8_rr_scheduler: two requesters share one WIDTH-bit adder, arbitrated round-robin.
// Ports: clk, rst (sync, active-high); inN_valid/inN_ready/inN_a/inN_b operand
// channels; outN_valid/outN_ready/outN_data result channels; ops_count = completed results.
module add8_rr_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_a,
  input  logic [WIDTH-1:0] in0_b,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_a,
  input  logic [WIDTH-1:0] in1_b,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [15:0]      ops_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, prio_q, prio_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum;
  logic [15:0] cnt_q, cnt_d;
  logic gnt, accept, done_hs;
  // the one shared adder; carry out is dropped by the WIDTH-bit result
  assign sum = a_q + b_q;
  always_comb begin
    gnt = (in0_valid && in1_valid) ? prio_q : in1_valid;
    accept = state_q == IDLE && (in0_valid || in1_valid);
    done_hs = state_q == DONE && (owner_q ? out1_ready : out0_ready);
    state_d = state_q == IDLE ? (accept ? BUSY : IDLE) :
              state_q == BUSY ? DONE :
              (state_q == DONE && !done_hs) ? DONE : IDLE;
    owner_d = accept ? gnt : owner_q;
    a_d = accept ? (gnt ? in1_a : in0_a) : a_q;
    b_d = accept ? (gnt ? in1_b : in0_b) : b_q;
    res_d = state_q == BUSY ? sum : res_q;
    prio_d = done_hs ? ~owner_q : prio_q;
    cnt_d = cnt_q + 16'(done_hs);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q <= prio_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end
  assign in0_ready = accept && !gnt;
  assign in1_ready = accept && gnt;
  assign out0_valid = state_q == DONE && !owner_q;
  assign out1_valid = state_q == DONE && owner_q;
  assign out0_data = res_q;
  assign out1_data = res_q;
  assign ops_count = cnt_q;
endmodule
